if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage of the 5-stage RV32 pipeline. Owns the PC, issues one request at a time to the
//  instruction memory, and presents fetched instructions to the IF/ID register.
//  A stall (IF/ID enable = !stall) holds the output buffer. An EX-stage redirect (taken branch or jump)
//  flushes the buffer, re-steers the PC and drops any in-flight response.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) driven when if_valid=0
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   asynchronous, active-high reset
//  stall           in   1   hazard unit: IF/ID not loading this cycle
//  redirect_valid  in   1   EX: taken branch or jump
//  redirect_pc     in   32  EX: target address; bits [1:0] are forced to 0
//  imem_req        out  1   request valid
//  imem_addr       out  32  request address
//  imem_gnt        in   1   request accepted this cycle (req & gnt = grant)
//  imem_rvalid     in   1   response valid; memory holds it until rready
//  imem_rdata      in   32  response instruction word
//  imem_rready     out  1   response consumed this cycle (rvalid & rready)
//  if_pc           out  32  PC of if_instr
//  if_instr        out  32  fetched instruction, or NOP_INSTR
//  if_valid        out  1   if_instr is a real fetched instruction
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=IDLE, if_valid=0, if_instr=NOP_INSTR, if_pc=0, req_pc=0.
//  imem_req is forced to 0 while rst=1.
//  Registers: pc (next fetch address), req_pc (address of the outstanding request), output buffer.
//  States:
//   IDLE  no request outstanding
//   WAIT  one request outstanding
//   DROP  request outstanding, but its response is discarded
//  Combinational outputs:
//   imem_addr = pc
//   accept    = WAIT & rvalid & rready & !redirect_valid
//   imem_req  = IDLE | accept
//   imem_rready = DROP | (WAIT & (redirect_valid | !if_valid | !stall))
//  Grant (req & gnt):
//   without redirect: req_pc<=pc, pc<=pc+4 (mod 2^32 wrap), next state WAIT
//   with redirect in the same cycle: pc<=redirect_pc, next state DROP (stale address)
//  Redirect, highest priority, overrides stall:
//   pc<={redirect_pc[31:2],2'b00}; if_valid<=0; if_instr<=NOP_INSTR; if_pc unchanged
//   IDLE: -> IDLE, or -> DROP if granted this cycle
//   WAIT: -> DROP if no response this cycle; if rvalid&rready this cycle, the response is
//         discarded and the next state is IDLE
//   DROP: stays DROP until its response is consumed
//  DROP & rvalid: response consumed and discarded -> IDLE. A new redirect in DROP only updates pc.
//  Output buffer, when there is no redirect:
//   accept:            if_valid<=1, if_instr<=rdata, if_pc<=req_pc
//   else if !stall:    if_valid<=0, if_instr<=NOP_INSTR (bubble)
//   else:              hold all outputs
//  accept: if the same cycle's request is granted, stay WAIT, so a 1-cycle memory sustains 1 instr/clk.
//   Otherwise -> IDLE.
//  No response is ever lost or duplicated. While stalled with if_valid=1, rready=0; the memory holds
//   the response.
//  At most one request outstanding. Latency: grant at cycle n, rvalid earliest at n+1, if_valid at n+2.
//  rvalid seen in IDLE is ignored (rready=0).
//  Reset mid-operation returns to IDLE; the memory side must be reset together with this block.
// TESTING
//  Reset -> after release, first imem_addr=0x0, if_valid=0, if_instr=0x00000013.
//  gnt=1 always, 1-cycle rvalid -> addrs 0,4,8,C...; if_valid steady from cycle 2; if_pc sequence 0,4,8.
//  stall=1 for 3 cycles with if_valid=1 -> if_pc/if_instr held, rready=0, no new grant; on release
//   no skipped or duplicated PC.
//  rvalid delayed 3 cycles, redirect_pc=0x100 in WAIT -> DROP, stale word discarded, next imem_addr=0x100,
//   if_valid=0 until the 0x100 word arrives.
//  redirect and stall in the same cycle with if_valid=1 -> next cycle if_valid=0, if_instr=NOP, pc=target.
//  redirect_pc=0x103 -> imem_addr=0x100. pc=0xFFFF_FFFC -> next pc=0x0 (wrap).

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight and
// buffers the fetched word for IF/ID, with redirect flush and stall hold.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_rready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, req_pc;
    logic        accept, grant, resp;

    assign imem_addr   = pc;
    // While the buffer is full and stalled, leave the response parked in memory.
    assign imem_rready = (state == S_DROP) ||
                         ((state == S_WAIT) && (redirect_valid || !if_valid || !stall));
    assign resp        = imem_rvalid && imem_rready;
    assign accept      = (state == S_WAIT) && resp && !redirect_valid;
    assign imem_req    = !rst && ((state == S_IDLE) || accept);
    assign grant       = imem_req && imem_gnt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant) state_nxt = redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) state_nxt = resp ? S_IDLE : S_DROP;
                else if (accept)    state_nxt = grant ? S_WAIT : S_IDLE;
            end
            S_DROP: begin
                if (resp) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= 32'h0;
        end else begin
            state <= state_nxt;
            // A grant in a redirect cycle fetches a stale address; DROP discards it.
            if (redirect_valid)
                pc <= {redirect_pc[31:2], 2'b00};
            else if (grant)
                pc <= pc + 32'd4;
            if (grant && !redirect_valid)
                req_pc <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= 32'h0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (accept) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= req_pc;
        end else if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed cycle-by-cycle bench for if_fetch: table of per-cycle inputs with hand-computed
// combinational and registered expectations, plus reset sequences.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, stall, redirect_valid, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, imem_rready, if_valid;
    logic [31:0] imem_addr, if_pc, if_instr;

    int total = 0;
    int bad   = 0;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .imem_rready    (imem_rready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_valid       (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_rready;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic rv, logic [31:0] rpc, logic g, logic rvl,
                                logic [31:0] rd, logic er, logic [31:0] ea, logic erd,
                                logic ev, logic [31:0] ep, logic [31:0] ei);
        vec_t v;
        v.stall = s;  v.rv = rv;  v.rpc = rpc;  v.gnt = g;  v.rvalid = rvl;  v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_rready = erd;
        v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // stall rv rpc gnt rvalid rdata | req addr rready | valid pc instr
        vecs.push_back(mk(0,0,0,1,0,0,                        1,32'h0,0,        0,32'h0,NOP));
        vecs.push_back(mk(0,0,0,1,1,32'h1111_1111,            1,32'h4,1,        1,32'h0,32'h1111_1111));
        vecs.push_back(mk(0,0,0,1,1,32'h2222_2222,            1,32'h8,1,        1,32'h4,32'h2222_2222));
        vecs.push_back(mk(1,0,0,1,1,32'h3333_3333,            0,32'hC,0,        1,32'h4,32'h2222_2222));
        vecs.push_back(mk(1,0,0,1,1,32'h3333_3333,            0,32'hC,0,        1,32'h4,32'h2222_2222));
        vecs.push_back(mk(1,0,0,1,1,32'h3333_3333,            0,32'hC,0,        1,32'h4,32'h2222_2222));
        vecs.push_back(mk(0,0,0,1,1,32'h3333_3333,            1,32'hC,1,        1,32'h8,32'h3333_3333));
        vecs.push_back(mk(1,0,0,1,0,0,                        0,32'h10,0,       1,32'h8,32'h3333_3333));
        vecs.push_back(mk(1,1,32'h103,1,0,0,                  0,32'h10,1,       0,32'h8,NOP));
        vecs.push_back(mk(0,0,0,1,0,0,                        0,32'h100,1,      0,32'h8,NOP));
        vecs.push_back(mk(0,0,0,1,1,32'hDEAD_BEEF,            0,32'h100,1,      0,32'h8,NOP));
        vecs.push_back(mk(0,0,0,1,0,0,                        1,32'h100,0,      0,32'h8,NOP));
        vecs.push_back(mk(0,0,0,0,1,32'h4444_4444,            1,32'h104,1,      1,32'h100,32'h4444_4444));
        vecs.push_back(mk(0,0,0,0,0,0,                        1,32'h104,0,      0,32'h100,NOP));
        vecs.push_back(mk(0,1,32'h200,1,0,0,                  1,32'h104,0,      0,32'h100,NOP));
        vecs.push_back(mk(0,0,0,1,1,32'h0000_0BAD,            0,32'h200,1,      0,32'h100,NOP));
        vecs.push_back(mk(0,0,0,1,0,0,                        1,32'h200,0,      0,32'h100,NOP));
        vecs.push_back(mk(0,1,32'h300,1,1,32'h0000_BAD2,      0,32'h204,1,      0,32'h100,NOP));
        vecs.push_back(mk(0,0,0,1,0,0,                        1,32'h300,0,      0,32'h100,NOP));
        vecs.push_back(mk(0,1,32'hFFFF_FFFC,1,0,0,            0,32'h304,1,      0,32'h100,NOP));
        vecs.push_back(mk(0,0,0,1,1,32'h0000_BAD3,            0,32'hFFFF_FFFC,1,0,32'h100,NOP));
        vecs.push_back(mk(0,0,0,1,0,0,                        1,32'hFFFF_FFFC,0,0,32'h100,NOP));
        vecs.push_back(mk(0,0,0,1,1,32'h5555_5555,            1,32'h0,1,        1,32'hFFFF_FFFC,32'h5555_5555));
        vecs.push_back(mk(0,0,0,0,1,32'h6666_6666,            1,32'h4,1,        1,32'h0,32'h6666_6666));
        vecs.push_back(mk(0,0,0,0,1,32'h7777_7777,            1,32'h4,0,        0,32'h0,NOP));

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",    {31'b0, imem_req}, 32'h0);
        chk("rst_valid",  {31'b0, if_valid}, 32'h0);
        chk("rst_instr",  if_instr, NOP);
        chk("rst_if_pc",  if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req",  {31'b0, imem_req}, 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            stall       = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),   imem_addr,            vecs[i].e_addr);
            chk($sformatf("v%0d_rready", i), {31'b0, imem_rready}, {31'b0, vecs[i].e_rready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i),  {31'b0, if_valid},    {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_if_pc", i),  if_pc,                vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i),  if_instr,             vecs[i].e_instr);
            @(negedge clk);
        end

        // Mid-operation reset with a request outstanding and a live buffer.
        stall = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 32'h8888_8888; imem_gnt = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", {31'b0, if_valid}, 32'h1);
        chk("pre_rst_if_pc", if_pc, 32'h4);
        @(negedge clk);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_req",    {31'b0, imem_req}, 32'h0);
        chk("mid_rst_addr",   imem_addr, 32'h0);
        chk("mid_rst_rready", {31'b0, imem_rready}, 32'h0);
        chk("mid_rst_valid",  {31'b0, if_valid}, 32'h0);
        chk("mid_rst_instr",  if_instr, NOP);
        chk("mid_rst_if_pc",  if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_req",  {31'b0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
